// File: rtl/uart_frame_loader.sv
// uart_frame_loader: hunts for a two-byte sync header on the UART byte
// stream, then writes NPIX pixel bytes into the back bank of a double-buffered
// framebuffer. The banks swap only after a complete frame has arrived.
// A gap timer aborts a frame if the stream stalls inside it.
// Optional feature macro: UART_FRAME_CHECKSUM_EN. When it is defined, a
// trailing XOR checksum byte must match before the bank swap happens.
module uart_frame_loader #(
  parameter int         H_PIX       = 16,
  parameter int         V_PIX       = 16,
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] SYNC0       = 8'hAA,
  parameter logic [7:0] SYNC1       = 8'h55,
  parameter int         TIMEOUT_CYC = 43400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              fb_we,
  output logic [ADDR_W:0]   fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int                NPIX     = H_PIX * V_PIX;
  localparam int                GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LOAD,
`ifdef UART_FRAME_CHECKSUM_EN
    S_CHK,
`endif
    S_COMMIT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pix_q;
  logic [GAP_W-1:0]    gap_q;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic timed, expire;
  logic we_d, done_d, err_d, swap, pix_clr, pix_inc, gap_inc;

  // Next-state and per-cycle control decode
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    swap    = 1'b0;
    pix_clr = 1'b0;
    pix_inc = 1'b0;
    timed   = (state_q == S_SYNC) || (state_q == S_LOAD);
`ifdef UART_FRAME_CHECKSUM_EN
    if (state_q == S_CHK) timed = 1'b1;
`endif
    // A byte arriving in the expiry cycle wins over the timeout.
    expire  = timed && !rx_dv && (gap_q == GAP_MAX);
    gap_inc = timed && !rx_dv && !expire;

    case (state_q)
      S_IDLE: begin
        if (rx_dv && (rx_byte == SYNC0)) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (rx_dv) begin
          if (rx_byte == SYNC1) begin
            state_d = S_LOAD;
            pix_clr = 1'b1;
          end else if (rx_byte != SYNC0) begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        // Header values inside the frame are ordinary pixel data.
        if (rx_dv) begin
          we_d    = 1'b1;
          pix_inc = 1'b1;
          if (pix_q == LAST_PIX) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_COMMIT;
`endif
          end
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      S_CHK: begin
        if (rx_dv) begin
          if (rx_byte == csum_q) begin
            state_d = S_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_COMMIT: begin
        // Any byte strobed during this cycle is deliberately dropped.
        swap    = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (expire) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  // State, pixel counter and gap timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pix_clr) begin
        pix_q <= '0;
      end else if (pix_inc) begin
        pix_q <= (pix_q == LAST_PIX) ? '0 : pix_q + ADDR_W'(1);
      end
      gap_q <= gap_inc ? gap_q + GAP_W'(1) : '0;
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // Running XOR of the pixel bytes of the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (pix_clr) begin
      csum_q <= '0;
    end else if (we_d) begin
      csum_q <= csum_q ^ rx_byte;
    end
  end
`endif

  // Registered write port, status pulses and displayed-bank flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      disp_bank  <= 1'b0;
    end else begin
      fb_we      <= we_d;
      frame_done <= done_d;
      frame_err  <= err_d;
      if (we_d) begin
        fb_addr  <= {~disp_bank, pix_q};
        fb_wdata <= rx_byte;
      end
      if (swap) disp_bank <= ~disp_bank;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader. A byte-stream model predicts
// every framebuffer write (address, data, cycle) and every done/err pulse;
// a negedge monitor compares the DUT against those predictions.
// Honours UART_FRAME_CHECKSUM_EN the same way the design does.
`timescale 1ns/1ps
module tb_uart_frame_loader;
  localparam int T  = 300;
  localparam int NP = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       fb_we;
  logic [8:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       disp_bank, frame_done, frame_err, busy;

  uart_frame_loader #(
    .H_PIX(16), .V_PIX(16), .ADDR_W(8),
    .SYNC0(8'hAA), .SYNC1(8'h55), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .disp_bank(disp_bank), .frame_done(frame_done),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [8:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { bit is_err; bit bank; } ev_t;
  wr_t        wq[$];
  ev_t        eq[$];
  logic [8:0] addr_log[$];
  int         n_done = 0;
  int         n_err  = 0;

  // Byte-stream model
  typedef enum { M_IDLE, M_SYNC, M_LOAD, M_CHK, M_COMMIT } mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_gap  = 0;
  int         m_pix  = 0;
  logic [7:0] m_csum = 8'h00;
  bit         m_disp = 1'b0;

  function automatic void model_reset();
    m_mode = M_IDLE; m_gap = 0; m_pix = 0; m_csum = 8'h00; m_disp = 1'b0;
  endfunction

  function automatic void finish_frame();
    m_disp = ~m_disp;
    eq.push_back('{is_err: 1'b0, bank: m_disp});
    m_mode = M_COMMIT;
  endfunction

  function automatic void model_idle(input int n);
    if (n > 0) begin
      m_gap += n;
      if (m_mode == M_COMMIT) m_mode = M_IDLE;
      if ((m_mode == M_SYNC || m_mode == M_LOAD || m_mode == M_CHK) && m_gap >= T) begin
        eq.push_back('{is_err: 1'b1, bank: m_disp});
        m_mode = M_IDLE;
      end
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int wcyc);
    m_gap = 0;
    case (m_mode)
      M_COMMIT: m_mode = M_IDLE;
      M_IDLE:   if (b == 8'hAA) m_mode = M_SYNC;
      M_SYNC: begin
        if (b == 8'h55) begin
          m_mode = M_LOAD; m_pix = 0; m_csum = 8'h00;
        end else if (b != 8'hAA) begin
          m_mode = M_IDLE;
        end
      end
      M_LOAD: begin
        wq.push_back('{addr: {~m_disp, 8'(m_pix)}, data: b, cyc: wcyc});
        m_csum ^= b;
        m_pix++;
        if (m_pix == NP) begin
          m_pix = 0;
`ifdef UART_FRAME_CHECKSUM_EN
          m_mode = M_CHK;
`else
          finish_frame();
`endif
        end
      end
      M_CHK: begin
        if (b == m_csum) begin
          finish_frame();
        end else begin
          eq.push_back('{is_err: 1'b1, bank: m_disp});
          m_mode = M_IDLE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  // Monitor: every write and every status pulse must match the model
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (rst_n) begin
      if (fb_we) begin
        checks++;
        addr_log.push_back(fb_addr);
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr=%h data=%h at cyc %0d, required no write", fb_addr, fb_wdata, cyc);
        end else begin
          w = wq.pop_front();
          if (fb_addr !== w.addr || fb_wdata !== w.data || cyc != w.cyc) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                     fb_addr, fb_wdata, cyc, w.addr, w.data, w.cyc);
          end
        end
      end
      if (frame_done || frame_err) begin
        checks++;
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
        if (frame_done && frame_err) begin
          errors++;
          $display("FAIL event_both: got done=1 err=1, required at most one");
        end else if (eq.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected: got done=%b err=%b, required none", frame_done, frame_err);
        end else begin
          e = eq.pop_front();
          if (frame_err !== e.is_err || disp_bank !== e.bank) begin
            errors++;
            $display("FAIL event: got err=%b bank=%b, required err=%b bank=%b",
                     frame_err, disp_bank, e.is_err, e.bank);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    model_idle(n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    rx_byte = b;
    rx_dv   = 1'b1;
    model_byte(b, cyc + 1);
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  // mode 0: index, 1: constant 3C, 2: random; returns the XOR of the bytes
  task automatic pixels(input int mode, input int n, input int maxgap, output logic [7:0] x);
    logic [7:0] b;
    x = 8'h00;
    for (int p = 0; p < n; p++) begin
      b = (mode == 0) ? 8'(p) : (mode == 1) ? 8'h3C : 8'($urandom_range(0, 255));
      send(b, int'($urandom_range(0, maxgap)));
      x ^= b;
    end
  endtask

  initial begin
    int         m, nd, ne;
    int         g, r;
    logic [7:0] x, b;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({fb_we, fb_addr, fb_wdata, disp_bank, frame_done, frame_err, busy}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame of 0..255 into bank 1
    m = addr_log.size(); nd = n_done;
    send(8'hAA, 1); send(8'h55, 0);
    pixels(0, NP, 2, x);
`ifdef UART_FRAME_CHECKSUM_EN
    send(x, 1);
`endif
    idle(4);
    chk("t1_write_count", 32'(addr_log.size() - m), 32'd256);
    chk("t1_first_addr", 32'(addr_log[m]), 32'h100);
    chk("t1_last_addr", 32'(addr_log[addr_log.size() - 1]), 32'h1FF);
    chk("t1_done_count", 32'(n_done - nd), 32'd1);
    chk("t1_disp_bank", 32'(disp_bank), 32'd1);

    // Constant frame into bank 0
    m = addr_log.size();
    send(8'hAA, 2); send(8'h55, 1);
    chk("t2_busy_loading", 32'(busy), 32'd1);
    pixels(1, NP, 1, x);
`ifdef UART_FRAME_CHECKSUM_EN
    send(x, 0);
`endif
    idle(4);
    chk("t2_first_addr", 32'(addr_log[m]), 32'h000);
    chk("t2_last_addr", 32'(addr_log[addr_log.size() - 1]), 32'h0FF);
    chk("t2_disp_bank", 32'(disp_bank), 32'd0);

    // Repeated first sync byte re-arms the header hunt
    m = addr_log.size();
    send(8'hAA, 1); send(8'hAA, 0); send(8'h55, 0);
    pixels(2, NP, 2, x);
`ifdef UART_FRAME_CHECKSUM_EN
    send(x, 1);
`endif
    idle(4);
    chk("t3_rearm_writes", 32'(addr_log.size() - m), 32'd256);
    chk("t3_disp_bank", 32'(disp_bank), 32'd1);

    // Broken header followed by junk must not write
    m = addr_log.size();
    send(8'hAA, 1); send(8'h12, 0); send(8'h55, 0);
    for (int j = 0; j < 20; j++) send(8'($urandom_range(0, 8'hA9)), int'($urandom_range(0, 2)));
    idle(3);
    chk("t3_junk_writes", 32'(addr_log.size() - m), 32'd0);
    chk("t3_junk_busy", 32'(busy), 32'd0);

    // Stall after 100 pixels: timeout, no swap
    m = addr_log.size(); ne = n_err; nd = n_done;
    send(8'hAA, 1); send(8'h55, 0);
    pixels(2, 100, 2, x);
    idle(T);
    idle(2);
    chk("t4_first_addr", 32'(addr_log[m]), 32'h000);
    chk("t4_err_count", 32'(n_err - ne), 32'd1);
    chk("t4_no_done", 32'(n_done - nd), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_disp_bank", 32'(disp_bank), 32'd1);

    // Reset in the middle of a frame
    send(8'hAA, 1); send(8'h55, 0);
    pixels(2, 50, 1, x);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", 32'({fb_we, disp_bank, frame_done, frame_err, busy}), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m = addr_log.size();
    send(8'hAA, 1); send(8'h55, 0);
    pixels(0, NP, 1, x);
`ifdef UART_FRAME_CHECKSUM_EN
    send(x, 1);
`endif
    // A byte in the commit cycle is dropped, so the following 55 is not a header
    send(8'hAA, 0); send(8'h55, 1);
    for (int j = 0; j < 3; j++) send(8'h07, 1);
    idle(4);
    chk("t5_first_addr", 32'(addr_log[m]), 32'h100);
    chk("t5_write_count", 32'(addr_log.size() - m), 32'd256);
    chk("t5_disp_bank", 32'(disp_bank), 32'd1);

`ifdef UART_FRAME_CHECKSUM_EN
    // Checksum pass, then checksum fail
    nd = n_done; ne = n_err;
    send(8'hAA, 1); send(8'h55, 0);
    pixels(0, NP, 1, x);
    send(8'h00, 1);
    idle(4);
    chk("t6_ok_done", 32'(n_done - nd), 32'd1);
    chk("t6_ok_disp", 32'(disp_bank), 32'd0);
    send(8'hAA, 1); send(8'h55, 0);
    pixels(0, NP, 1, x);
    send(8'h01, 1);
    idle(4);
    chk("t6_bad_err", 32'(n_err - ne), 32'd1);
    chk("t6_bad_disp", 32'(disp_bank), 32'd0);
`endif

    // Randomised streams, including gaps at and past the timeout boundary
    for (int it = 0; it < 6; it++) begin
      r = int'($urandom_range(0, 3));
      for (int j = 0; j < r; j++) send(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) send(8'hAA, 1);
      send(8'hAA, int'($urandom_range(0, 2)));
      send(8'h55, int'($urandom_range(0, 2)));
      x = 8'h00;
      for (int p = 0; p < NP; p++) begin
        b = 8'($urandom_range(0, 255));
        r = int'($urandom_range(0, 99));
        if (r == 0)                 g = T - 1;
        else if (r == 1 && it >= 3) g = T + int'($urandom_range(0, 3));
        else                        g = int'($urandom_range(0, 2));
        send(b, g);
        x ^= b;
      end
`ifdef UART_FRAME_CHECKSUM_EN
      send(($urandom_range(0, 1) == 1) ? x : (x ^ 8'h01), int'($urandom_range(0, 2)));
`endif
      idle(int'($urandom_range(0, 3)));
    end
    idle(T + 5);
    idle(3);
    chk("drain_writes", 32'(wq.size()), 32'd0);
    chk("drain_events", 32'(eq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
